// File: rtl/drag_race_pkg.sv
// rtl/drag_race_pkg.sv - shared lane-timing types, defaults and light/beam conventions
package drag_race_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_REACT = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_FOUL  = 3'd5
    } state_t;

    localparam int MS_W_DEFAULT = 16;

    // Tree lamps and lane beams are all active-high.
    localparam logic LIGHT_ON     = 1'b1;
    localparam logic BEAM_BLOCKED = 1'b1;

endpackage

// File: rtl/drag_reaction_timer_if.sv
// rtl/drag_reaction_timer_if.sv - tree/beam inputs and result outputs of one timing lane
interface drag_reaction_timer_if
    import drag_race_pkg::*;
#(
    parameter int MS_W = MS_W_DEFAULT
) ();

    logic            G;
    logic            R;
    logic            SB;
    logic            FB;
    logic [MS_W-1:0] react_ms;
    logic [MS_W-1:0] elapsed_ms;
    logic            valid;
    logic            foul;
    logic            timeout;
    logic            busy;

    modport master (
        output G, R, SB, FB,
        input  react_ms, elapsed_ms, valid, foul, timeout, busy
    );

    modport slave (
        input  G, R, SB, FB,
        output react_ms, elapsed_ms, valid, foul, timeout, busy
    );

endinterface

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond prescaler, tick high on the terminal count
module ms_tick_gen
    import drag_race_pkg::*;
#(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic CLOCK_50,
    input  logic Reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_MS - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM);

    always_ff @(posedge CLOCK_50) begin
        if (Reset || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/drag_reaction_timer.sv
// rtl/drag_reaction_timer.sv - lane reaction/elapsed timer with foul and timeout flags
module drag_reaction_timer
    import drag_race_pkg::*;
#(
    parameter int CLKS_PER_MS = 50000,
    parameter int TIMEOUT_MS  = 20000,
    parameter int MS_W        = MS_W_DEFAULT
) (
    input  logic                  CLOCK_50,
    input  logic                  Reset,
    drag_reaction_timer_if.slave  lane
);

    localparam logic [MS_W-1:0] MS_MAX      = '1;
    localparam logic [31:0]     TIMEOUT_LIM = 32'(TIMEOUT_MS);

    state_t          state;
    logic            sb_meta, sb_s, sb_prev;
    logic            fb_meta, fb_s, fb_prev;
    logic            g_prev;
    logic [MS_W-1:0] react_cnt, elapsed_cnt;
    logic [MS_W-1:0] react_next, elapsed_next;
    logic [MS_W-1:0] react_q, elapsed_q;
    logic            valid_q, foul_q, timeout_q, busy_q;

    logic tick;
    logic g_on, r_on;
    logic g_rise, sb_fall, fb_rise;
    logic go_react, at_limit;

    assign g_on    = (lane.G == LIGHT_ON);
    assign r_on    = (lane.R == LIGHT_ON);
    assign g_rise  = g_on & ~g_prev;
    assign sb_fall = sb_prev & ~sb_s;
    assign fb_rise = fb_s & ~fb_prev;

    // Counter values including a tick landing on this very cycle, so latches are never one ms short.
    always_comb begin
        react_next   = react_cnt;
        elapsed_next = elapsed_cnt;
        if (tick && (react_cnt != MS_MAX)) begin
            react_next = react_cnt + 1'b1;
        end
        if (tick && (elapsed_cnt != MS_MAX)) begin
            elapsed_next = elapsed_cnt + 1'b1;
        end
    end

    assign go_react = (state == S_ARMED) && !r_on && g_rise;
    assign at_limit = (32'(elapsed_next) >= TIMEOUT_LIM);

    ms_tick_gen #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .clr      (go_react),
        .tick     (tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state       <= S_IDLE;
            sb_meta     <= 1'b0;
            sb_s        <= 1'b0;
            sb_prev     <= 1'b0;
            fb_meta     <= 1'b0;
            fb_s        <= 1'b0;
            fb_prev     <= 1'b0;
            g_prev      <= 1'b0;
            react_cnt   <= '0;
            elapsed_cnt <= '0;
            react_q     <= '0;
            elapsed_q   <= '0;
            valid_q     <= 1'b0;
            foul_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sb_meta <= (lane.SB == BEAM_BLOCKED);
            sb_s    <= sb_meta;
            sb_prev <= sb_s;
            fb_meta <= (lane.FB == BEAM_BLOCKED);
            fb_s    <= fb_meta;
            fb_prev <= fb_s;
            g_prev  <= g_on;
            valid_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (sb_s) begin
                        state <= S_ARMED;
                    end
                end

                // Red beats a back-out: the tree lights R before the synchronized beam drops.
                S_ARMED: begin
                    if (r_on) begin
                        state  <= S_FOUL;
                        foul_q <= 1'b1;
                    end else if (g_rise) begin
                        state       <= S_REACT;
                        react_cnt   <= '0;
                        elapsed_cnt <= '0;
                        busy_q      <= 1'b1;
                    end else if (!sb_s) begin
                        state <= S_IDLE;
                    end
                end

                S_REACT: begin
                    react_cnt   <= react_next;
                    elapsed_cnt <= elapsed_next;
                    if (r_on) begin
                        state  <= S_FOUL;
                        foul_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (sb_fall) begin
                        state   <= S_RUN;
                        react_q <= react_next;
                    end else if (at_limit) begin
                        state     <= S_DONE;
                        react_q   <= react_next;
                        elapsed_q <= elapsed_next;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end

                S_RUN: begin
                    elapsed_cnt <= elapsed_next;
                    if (r_on) begin
                        state  <= S_FOUL;
                        foul_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (fb_rise) begin
                        state     <= S_DONE;
                        elapsed_q <= elapsed_next;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end else if (at_limit) begin
                        state     <= S_DONE;
                        elapsed_q <= elapsed_next;
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end

                S_DONE, S_FOUL: begin
                    state <= state;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign lane.react_ms   = react_q;
    assign lane.elapsed_ms = elapsed_q;
    assign lane.valid      = valid_q;
    assign lane.foul       = foul_q;
    assign lane.timeout    = timeout_q;
    assign lane.busy       = busy_q;

endmodule
